// File: rtl/ucie_ctl_rdi_pkg.sv
// Shared RDI definitions for the adapter-side link controller: RDI state
// encodings, the link sequencer FSM states and the default handshake budget.
package ucie_ctl_rdi_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [3:0] {
        RDI_NOP       = 4'b0000,
        RDI_ACTIVE    = 4'b0001,
        RDI_LINKRESET = 4'b1001,
        RDI_LINKERROR = 4'b1010,
        RDI_RETRAIN   = 4'b1011
    } rdi_state_e;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_WAIT_PRES,
        SEQ_REQ_ACTIVE,
        SEQ_ACTIVE,
        SEQ_RETRAIN_WAIT,
        SEQ_LINKRESET,
        SEQ_LINKERR
    } seq_state_e;

    // lp_state_req driven while the sequencer sits in a given state
    function automatic rdi_state_e seq_state_req(input seq_state_e s);
        case (s)
            SEQ_REQ_ACTIVE,
            SEQ_ACTIVE,
            SEQ_RETRAIN_WAIT: return RDI_ACTIVE;
            SEQ_LINKRESET:    return RDI_LINKRESET;
            default:          return RDI_NOP;
        endcase
    endfunction

endpackage

// File: rtl/ucie_ctl_timeout_counter.sv
// Handshake step timer: synchronous clear, count enable, and a terminal-count
// flag raised on the last allowed cycle of the step.
module ucie_ctl_timeout_counter
    import ucie_ctl_rdi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count;

    assign tc = (count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Holds at terminal count; the owner is expected to clear on step exit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ucie_ctl_rdi_link_sequencer.sv
// RDI link bring-up sequencer: drives lp_state_req/lp_linkerror from CSR and
// PHY status, and gates the adapter TX stream so data flows only when Active.
module ucie_ctl_rdi_link_sequencer
    import ucie_ctl_rdi_pkg::*;
#(
    parameter int NBYTES         = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start_link,
    input  logic                i_linkreset_req,
    input  logic                i_err_clear,
    input  logic [3:0]          i_pl_state_sts,
    input  logic                i_pl_inband_pres,
    input  logic                i_pl_error,
    input  logic                i_pl_trainerror,
    input  logic                i_pl_trdy,
    input  logic                i_tx_valid,
    input  logic [NBYTES*8-1:0] i_tx_data,
    output logic                o_tx_ready,
    output logic [3:0]          o_lp_state_req,
    output logic                o_lp_linkerror,
    output logic                o_lp_valid,
    output logic                o_lp_irdy,
    output logic [NBYTES*8-1:0] o_lp_data,
    output logic                o_link_up,
    output logic                o_timeout_err
);

    localparam int DATA_W = NBYTES * 8;

    seq_state_e state;
    seq_state_e state_nxt;
    rdi_state_e state_req_q;
    logic       linkerror_q;
    logic       link_up_q;
    logic       timeout_err_q;

    logic       pl_err;
    logic       exit_cond;
    logic       timer_en;
    logic       timer_clr;
    logic       timer_tc;
    logic       timeout_hit;

    assign pl_err    = i_pl_error | i_pl_trainerror;
    assign timer_clr = (state_nxt != state);

    ucie_ctl_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .tc    (timer_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        exit_cond   = 1'b0;
        timer_en    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (i_start_link) state_nxt = SEQ_WAIT_PRES;
            end
            SEQ_WAIT_PRES: begin
                timer_en  = 1'b1;
                exit_cond = i_pl_inband_pres;
                if (exit_cond) state_nxt = SEQ_REQ_ACTIVE;
            end
            SEQ_REQ_ACTIVE: begin
                timer_en  = 1'b1;
                exit_cond = (i_pl_state_sts == RDI_ACTIVE);
                if (exit_cond) state_nxt = SEQ_ACTIVE;
            end
            SEQ_ACTIVE: begin
                if (i_linkreset_req)                     state_nxt = SEQ_LINKRESET;
                else if (i_pl_state_sts == RDI_RETRAIN)  state_nxt = SEQ_RETRAIN_WAIT;
                else if (!i_start_link)                  state_nxt = SEQ_LINKRESET;
            end
            SEQ_RETRAIN_WAIT: begin
                timer_en  = 1'b1;
                exit_cond = (i_pl_state_sts == RDI_ACTIVE);
                if (exit_cond) state_nxt = SEQ_ACTIVE;
            end
            SEQ_LINKRESET: begin
                timer_en  = 1'b1;
                exit_cond = (i_pl_state_sts == RDI_LINKRESET);
                if (exit_cond) state_nxt = SEQ_IDLE;
            end
            SEQ_LINKERR: begin
                if (i_err_clear) state_nxt = SEQ_IDLE;
            end
            default: state_nxt = SEQ_IDLE;
        endcase

        // A step exit seen on the terminal cycle beats the timeout
        if (timer_en && timer_tc && !exit_cond) begin
            state_nxt   = SEQ_LINKERR;
            timeout_hit = 1'b1;
        end

        // PHY errors override everything once bring-up has started
        if (pl_err && state != SEQ_IDLE && state != SEQ_LINKERR) begin
            state_nxt   = SEQ_LINKERR;
            timeout_hit = 1'b0;
        end
    end

    // Moore outputs are registered from the next state so they line up with state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_req_q   <= RDI_NOP;
            linkerror_q   <= 1'b0;
            link_up_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_req_q <= seq_state_req(state_nxt);
            linkerror_q <= (state_nxt == SEQ_LINKERR);
            link_up_q   <= (state_nxt == SEQ_ACTIVE);
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end else if (state == SEQ_LINKERR && i_err_clear) begin
                timeout_err_q <= 1'b0;
            end
        end
    end

    assign o_lp_state_req = state_req_q;
    assign o_lp_linkerror = linkerror_q;
    assign o_link_up      = link_up_q;
    assign o_timeout_err  = timeout_err_q;

    // Zero-latency gating; async reset clears link_up_q and so kills the stream at once
    assign o_lp_valid = link_up_q & i_tx_valid;
    assign o_lp_irdy  = link_up_q & i_tx_valid;
    assign o_tx_ready = link_up_q & i_pl_trdy;
    assign o_lp_data  = link_up_q ? i_tx_data : {DATA_W{1'b0}};

endmodule

// File: tb/tb_ucie_ctl_rdi_link_sequencer.sv
// Bench for the RDI link sequencer: directed bring-up/timeout/retrain/reset
// scenarios plus randomized traffic, all checked against a behavioural model.
module tb_ucie_ctl_rdi_link_sequencer;

    localparam int NB = 8;
    localparam int DW = NB * 8;
    localparam int TO = 16;

    localparam int P_IDLE  = 0;
    localparam int P_WPRES = 1;
    localparam int P_REQ   = 2;
    localparam int P_ACT   = 3;
    localparam int P_RETR  = 4;
    localparam int P_LRST  = 5;
    localparam int P_LERR  = 6;

    localparam logic [3:0] S_NOP = 4'b0000;
    localparam logic [3:0] S_ACT = 4'b0001;
    localparam logic [3:0] S_LRS = 4'b1001;
    localparam logic [3:0] S_RTR = 4'b1011;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start_link = 1'b0;
    logic          i_linkreset_req = 1'b0;
    logic          i_err_clear = 1'b0;
    logic [3:0]    i_pl_state_sts = 4'b0;
    logic          i_pl_inband_pres = 1'b0;
    logic          i_pl_error = 1'b0;
    logic          i_pl_trainerror = 1'b0;
    logic          i_pl_trdy = 1'b0;
    logic          i_tx_valid = 1'b0;
    logic [DW-1:0] i_tx_data = '0;
    logic          o_tx_ready;
    logic [3:0]    o_lp_state_req;
    logic          o_lp_linkerror;
    logic          o_lp_valid;
    logic          o_lp_irdy;
    logic [DW-1:0] o_lp_data;
    logic          o_link_up;
    logic          o_timeout_err;

    always #5 i_clk = ~i_clk;

    ucie_ctl_rdi_link_sequencer #(
        .NBYTES         (NB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_start_link     (i_start_link),
        .i_linkreset_req  (i_linkreset_req),
        .i_err_clear      (i_err_clear),
        .i_pl_state_sts   (i_pl_state_sts),
        .i_pl_inband_pres (i_pl_inband_pres),
        .i_pl_error       (i_pl_error),
        .i_pl_trainerror  (i_pl_trainerror),
        .i_pl_trdy        (i_pl_trdy),
        .i_tx_valid       (i_tx_valid),
        .i_tx_data        (i_tx_data),
        .o_tx_ready       (o_tx_ready),
        .o_lp_state_req   (o_lp_state_req),
        .o_lp_linkerror   (o_lp_linkerror),
        .o_lp_valid       (o_lp_valid),
        .o_lp_irdy        (o_lp_irdy),
        .o_lp_data        (o_lp_data),
        .o_link_up        (o_link_up),
        .o_timeout_err    (o_timeout_err)
    );

    int n_vec = 0;
    int n_err = 0;

    int m_phase = P_IDLE;
    int m_wait  = 0;
    bit m_tout  = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic bound_fail(input string tag);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t (model phase %0d)", tag, $time, m_phase);
    endtask

    function automatic logic [3:0] model_req();
        if (m_phase == P_REQ || m_phase == P_ACT || m_phase == P_RETR) return S_ACT;
        if (m_phase == P_LRST) return S_LRS;
        return S_NOP;
    endfunction

    // Phases that are a bounded handshake step, and what ends each of them
    function automatic bit is_handshake(input int ph);
        return ph == P_WPRES || ph == P_REQ || ph == P_RETR || ph == P_LRST;
    endfunction

    function automatic int handshake_target(input int ph);
        if (ph == P_WPRES) return i_pl_inband_pres ? P_REQ : -1;
        if (ph == P_LRST)  return (i_pl_state_sts == S_LRS) ? P_IDLE : -1;
        return (i_pl_state_sts == S_ACT) ? P_ACT : -1;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_wait  = 0;
        m_tout  = 1'b0;
    endtask

    task automatic model_step();
        int nxt;
        bit err;
        nxt = m_phase;
        err = i_pl_error || i_pl_trainerror;
        if (err && m_phase != P_IDLE && m_phase != P_LERR) begin
            nxt = P_LERR;
        end else if (is_handshake(m_phase)) begin
            if (handshake_target(m_phase) >= 0) begin
                nxt = handshake_target(m_phase);
            end else if (m_wait == TO - 1) begin
                nxt    = P_LERR;
                m_tout = 1'b1;
            end
        end else if (m_phase == P_IDLE) begin
            if (i_start_link) nxt = P_WPRES;
        end else if (m_phase == P_ACT) begin
            if (i_linkreset_req || (!i_start_link && i_pl_state_sts != S_RTR)) nxt = P_LRST;
            else if (i_pl_state_sts == S_RTR) nxt = P_RETR;
        end else if (m_phase == P_LERR && i_err_clear) begin
            nxt    = P_IDLE;
            m_tout = 1'b0;
        end
        m_wait  = (nxt != m_phase) ? 0 : m_wait + 1;
        m_phase = nxt;
    endtask

    task automatic check_outputs();
        bit act;
        act = (m_phase == P_ACT);
        check_val("state_req",   64'(o_lp_state_req), 64'(model_req()));
        check_val("linkerror",   64'(o_lp_linkerror), 64'(m_phase == P_LERR));
        check_val("link_up",     64'(o_link_up),      64'(act));
        check_val("timeout_err", 64'(o_timeout_err),  64'(m_tout));
        check_val("lp_valid",    64'(o_lp_valid),     64'(act && i_tx_valid));
        check_val("lp_irdy",     64'(o_lp_irdy),      64'(act && i_tx_valid));
        check_val("tx_ready",    64'(o_tx_ready),     64'(act && i_pl_trdy));
        check_val("lp_data",     o_lp_data,           act ? i_tx_data : 64'h0);
    endtask

    // Inputs are driven 1 time unit after a rising edge; checks follow 1 unit later
    task automatic tick();
        #1;
        check_outputs();
        @(posedge i_clk);
        if (i_rst_n) model_step();
        #1;
    endtask

    task automatic wait_phase(input int ph, input int max_cycles, input string tag);
        int n;
        n = 0;
        while (m_phase != ph && n < max_cycles) begin
            i_pl_trdy = ~i_pl_trdy;
            tick();
            n++;
        end
        if (m_phase != ph) bound_fail(tag);
    endtask

    task automatic clear_to_idle();
        i_start_link = 1'b0;
        i_err_clear  = 1'b1;
        tick();
        i_err_clear  = 1'b0;
        check_val("clr_linkerror", 64'(o_lp_linkerror), 64'h0);
        check_val("clr_timeout",   64'(o_timeout_err),  64'h0);
        check_val("clr_req",       64'(o_lp_state_req), 64'h0);
        tick();
    endtask

    task automatic bring_up();
        i_start_link     = 1'b1;
        i_pl_inband_pres = 1'b0;
        i_pl_state_sts   = S_NOP;
        i_tx_valid       = 1'b1;
        i_tx_data        = 64'hDEAD_BEEF_0123_4567;
        for (int k = 0; k < 5; k++) begin
            i_pl_trdy = ~i_pl_trdy;
            tick();
        end
        check_val("gate_data_pre",  o_lp_data,         64'h0);
        check_val("gate_valid_pre", 64'(o_lp_valid),   64'h0);
        i_pl_inband_pres = 1'b1;
        wait_phase(P_REQ, 4, "wait_req_active");
        check_val("bringup_req", 64'(o_lp_state_req), 64'h1);
        tick();
        tick();
        i_pl_state_sts = S_ACT;
        wait_phase(P_ACT, 4, "wait_active");
        check_val("bringup_link_up", 64'(o_link_up),     64'h1);
        check_val("bringup_timeout", 64'(o_timeout_err), 64'h0);
        for (int k = 0; k < 4; k++) begin
            i_pl_trdy = ~i_pl_trdy;
            #1;
            check_val("gate_data_act", o_lp_data,        64'hDEAD_BEEF_0123_4567);
            check_val("gate_ready",    64'(o_tx_ready),  64'(i_pl_trdy));
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] src_data;
        bit            accepted;
        int            r;

        model_reset();
        i_rst_n = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();

        // bring-up with data gating
        bring_up();

        // retrain for 4 cycles
        i_pl_state_sts = S_RTR;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("retrain_link_up", 64'(o_link_up),      64'h0);
            check_val("retrain_valid",   64'(o_lp_valid),     64'h0);
            check_val("retrain_req",     64'(o_lp_state_req), 64'h1);
        end
        i_pl_state_sts = S_ACT;
        tick();
        check_val("retrain_back", 64'(o_link_up), 64'h1);

        // error and LinkReset in the same ACTIVE cycle
        i_pl_error      = 1'b1;
        i_linkreset_req = 1'b1;
        tick();
        i_pl_error      = 1'b0;
        i_linkreset_req = 1'b0;
        check_val("simul_linkerror", 64'(o_lp_linkerror), 64'h1);
        check_val("simul_req",       64'(o_lp_state_req), 64'h0);
        tick();
        clear_to_idle();

        // timeout in WAIT_PRES
        i_pl_inband_pres = 1'b0;
        i_pl_state_sts   = S_NOP;
        i_start_link     = 1'b1;
        wait_phase(P_WPRES, 4, "wait_wpres_to");
        for (int k = 0; k < TO - 1; k++) tick();
        check_val("to_not_yet", 64'(o_lp_linkerror), 64'h0);
        tick();
        check_val("to_linkerror", 64'(o_lp_linkerror), 64'h1);
        check_val("to_sticky",    64'(o_timeout_err),  64'h1);
        tick();
        clear_to_idle();

        // presence arrives on the terminal timer cycle
        i_start_link = 1'b1;
        wait_phase(P_WPRES, 4, "wait_wpres_tc");
        for (int k = 0; k < TO - 1; k++) tick();
        i_pl_inband_pres = 1'b1;
        tick();
        check_val("tc_req",       64'(o_lp_state_req), 64'h1);
        check_val("tc_timeout",   64'(o_timeout_err),  64'h0);
        check_val("tc_linkerror", 64'(o_lp_linkerror), 64'h0);
        i_pl_state_sts = S_ACT;
        wait_phase(P_ACT, 4, "wait_active_tc");

        // asynchronous reset in the middle of a transfer
        i_tx_valid = 1'b1;
        i_pl_trdy  = 1'b1;
        #2;
        i_rst_n = 1'b0;
        #1;
        check_val("arst_link_up",   64'(o_link_up),      64'h0);
        check_val("arst_valid",     64'(o_lp_valid),     64'h0);
        check_val("arst_irdy",      64'(o_lp_irdy),      64'h0);
        check_val("arst_ready",     64'(o_tx_ready),     64'h0);
        check_val("arst_data",      o_lp_data,           64'h0);
        check_val("arst_req",       64'(o_lp_state_req), 64'h0);
        check_val("arst_linkerror", 64'(o_lp_linkerror), 64'h0);
        check_val("arst_timeout",   64'(o_timeout_err),  64'h0);
        model_reset();
        @(posedge i_clk);
        #1;
        tick();
        i_rst_n = 1'b1;
        tick();
        bring_up();

        // randomized traffic
        src_data   = {$urandom, $urandom};
        i_tx_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            accepted = (m_phase == P_ACT) && i_tx_valid && i_pl_trdy;
            i_start_link     = ($urandom_range(0, 15) != 0);
            i_pl_inband_pres = ($urandom_range(0, 3) == 0);
            i_pl_error       = ($urandom_range(0, 63) == 0);
            i_pl_trainerror  = ($urandom_range(0, 95) == 0);
            i_linkreset_req  = ($urandom_range(0, 31) == 0);
            i_err_clear      = ($urandom_range(0, 7) == 0);
            i_pl_trdy        = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 9);
            i_pl_state_sts = (r < 5) ? S_ACT : (r < 6) ? S_RTR : (r < 8) ? S_LRS : S_NOP;
            if (!i_tx_valid || accepted) begin
                i_tx_valid = $urandom_range(0, 3) != 0;
                src_data   = {$urandom, $urandom};
            end
            i_tx_data = src_data;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
